// File: rtl/mul_norm_round_if.sv
// mul_norm_round_if: handshake and data bundle between the product stage and the flag/packing stages.
interface mul_norm_round_if #(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [2*MANT_W-1:0]   prod_M_in;
    logic [EXP_W+1:0]      sum_E_in;
    logic                  initial_zero_flag;
    logic                  out_valid;
    logic                  out_ready;
    logic [MANT_W-1:0]     final_M_out;
    logic [EXP_W-1:0]      final_E_out;
    logic                  initial_zero_flag_out;
    logic                  overflow_flag;
    logic                  underflow_flag;

    modport master (
        output in_valid, prod_M_in, sum_E_in, initial_zero_flag, out_ready,
        input  in_ready, out_valid, final_M_out, final_E_out, initial_zero_flag_out,
               overflow_flag, underflow_flag
    );

    modport slave (
        input  in_valid, prod_M_in, sum_E_in, initial_zero_flag, out_ready,
        output in_ready, out_valid, final_M_out, final_E_out, initial_zero_flag_out,
               overflow_flag, underflow_flag
    );
endinterface

// File: rtl/mul_norm_round_stage.sv
// mul_norm_round_stage: two-stage normalize, round-to-nearest-even and exponent range check
// for the FP multiplier significand product, with valid/ready back-pressure.
module mul_norm_round_stage #(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8
) (
    input logic             CLK,
    input logic             RST,
    mul_norm_round_if.slave bus
);
    localparam int PW = 2 * MANT_W;
    localparam int EW = EXP_W + 2;
    localparam logic signed [EW:0] E_MAX = (EW+1)'((1 << EXP_W) - 1);

    logic              s1_valid_q, s2_en, s1_en;
    logic [MANT_W-1:0] s1_m_q, s1_m_d;
    logic              s1_g_q, s1_g_d, s1_s_q, s1_s_d, s1_z_q;
    logic [EW-1:0]     s1_e_q, s1_e_d;
    logic              out_valid_q;
    logic [MANT_W-1:0] m_q, m_d;
    logic [EXP_W-1:0]  e_q, e_d;
    logic              z_q, ovf_q, ovf_d, unf_q, unf_d;
    logic              top, round_up;
    logic [MANT_W:0]   m_sum;
    logic [MANT_W-1:0] m_r;
    logic signed [EW:0] e_r;

    assign s2_en        = !out_valid_q | bus.out_ready;
    assign s1_en        = !s1_valid_q | s2_en;
    assign bus.in_ready = s1_en;

    assign top = bus.prod_M_in[PW-1];

    always_comb begin
        s1_m_d = top ? bus.prod_M_in[PW-1:MANT_W] : bus.prod_M_in[PW-2:MANT_W-1];
        s1_g_d = top ? bus.prod_M_in[MANT_W-1] : bus.prod_M_in[MANT_W-2];
        s1_s_d = top ? |bus.prod_M_in[MANT_W-2:0] : |bus.prod_M_in[MANT_W-3:0];
        s1_e_d = bus.sum_E_in + EW'(top);
    end

    // Exponent is widened by one bit so the round carry cannot wrap the signed range check.
    always_comb begin
        round_up = s1_g_q & (s1_s_q | s1_m_q[0]);
        m_sum    = {1'b0, s1_m_q} + (MANT_W+1)'(round_up);
        m_r      = m_sum[MANT_W] ? m_sum[MANT_W:1] : m_sum[MANT_W-1:0];
        e_r      = $signed({s1_e_q[EW-1], s1_e_q}) + $signed((EW+1)'(m_sum[MANT_W]));
        ovf_d    = !s1_z_q && (e_r >= E_MAX);
        unf_d    = !s1_z_q && !ovf_d && (e_r <= 0);
        m_d      = (s1_z_q | ovf_d | unf_d) ? '0 : m_r;
        e_d      = (s1_z_q | unf_d) ? '0 : ovf_d ? '1 : e_r[EXP_W-1:0];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_valid_q <= 1'b0;
            s1_m_q     <= '0;
            s1_g_q     <= 1'b0;
            s1_s_q     <= 1'b0;
            s1_e_q     <= '0;
            s1_z_q     <= 1'b0;
        end else if (s1_en) begin
            s1_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                s1_m_q <= s1_m_d;
                s1_g_q <= s1_g_d;
                s1_s_q <= s1_s_d;
                s1_e_q <= s1_e_d;
                s1_z_q <= bus.initial_zero_flag;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            out_valid_q <= 1'b0;
            m_q         <= '0;
            e_q         <= '0;
            z_q         <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else if (s2_en) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                m_q   <= m_d;
                e_q   <= e_d;
                z_q   <= s1_z_q;
                ovf_q <= ovf_d;
                unf_q <= unf_d;
            end
        end
    end

    assign bus.out_valid             = out_valid_q;
    assign bus.final_M_out           = m_q;
    assign bus.final_E_out           = e_q;
    assign bus.initial_zero_flag_out = z_q;
    assign bus.overflow_flag         = ovf_q;
    assign bus.underflow_flag        = unf_q;
endmodule

// File: tb/tb_mul_norm_round_stage.sv
// tb_mul_norm_round_stage: directed vector table plus back-pressure and mid-stream reset sequences.
module tb_mul_norm_round_stage;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    mul_norm_round_if bus ();
    mul_norm_round_stage dut (.CLK(CLK), .RST(RST), .bus(bus));

    typedef struct {
        logic [47:0] prod;
        logic [9:0]  se;
        logic        z;
        logic [23:0] m;
        logic [7:0]  e;
        logic        ovf;
        logic        unf;
    } vec_t;

    vec_t tv[14];
    int tests = 0;
    int fails = 0;
    int sent, got;
    logic acc, drn;
    logic [7:0] de;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return 64'({bus.out_valid, bus.initial_zero_flag_out, bus.overflow_flag,
                    bus.underflow_flag, bus.final_E_out, bus.final_M_out});
    endfunction

    task automatic drive(input logic v, input logic [47:0] p, input logic [9:0] se, input logic z);
        bus.in_valid          = v;
        bus.prod_M_in         = p;
        bus.sum_E_in          = se;
        bus.initial_zero_flag = z;
    endtask

    initial begin
        tv[0]  = '{48'h400000000000, 10'd127, 1'b0, 24'h800000, 8'h7F, 1'b0, 1'b0};
        tv[1]  = '{48'h900000000000, 10'd127, 1'b0, 24'h900000, 8'h80, 1'b0, 1'b0};
        tv[2]  = '{48'h400000C00000, 10'd127, 1'b0, 24'h800002, 8'h7F, 1'b0, 1'b0};
        tv[3]  = '{48'h7FFFFFC00000, 10'd100, 1'b0, 24'h800000, 8'd101, 1'b0, 1'b0};
        tv[4]  = '{48'h800000000000, 10'd254, 1'b0, 24'h000000, 8'hFF, 1'b1, 1'b0};
        tv[5]  = '{48'h400000000000, 10'h3F0, 1'b0, 24'h000000, 8'h00, 1'b0, 1'b1};
        tv[6]  = '{48'h000000000000, 10'd300, 1'b1, 24'h000000, 8'h00, 1'b0, 1'b0};
        tv[7]  = '{48'h800000000000, 10'd253, 1'b0, 24'h800000, 8'hFE, 1'b0, 1'b0};
        tv[8]  = '{48'h400000000000, 10'd1,   1'b0, 24'h800000, 8'h01, 1'b0, 1'b0};
        tv[9]  = '{48'h400000000000, 10'd0,   1'b0, 24'h000000, 8'h00, 1'b0, 1'b1};
        tv[10] = '{48'h7FFFFFC00000, 10'd254, 1'b0, 24'h000000, 8'hFF, 1'b1, 1'b0};
        tv[11] = '{48'h400000400000, 10'd127, 1'b0, 24'h800000, 8'h7F, 1'b0, 1'b0};
        tv[12] = '{48'h400000600000, 10'd127, 1'b0, 24'h800001, 8'h7F, 1'b0, 1'b0};
        tv[13] = '{48'h000000000000, 10'h3F0, 1'b1, 24'h000000, 8'h00, 1'b0, 1'b0};

        drive(1'b0, '0, '0, 1'b0);
        bus.out_ready = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        chk("reset_outs", outs(), 64'h0);
        chk("reset_in_ready", bus.in_ready, 1'b1);

        for (int i = 0; i < 14; i++) begin
            @(negedge CLK);
            drive(1'b1, tv[i].prod, tv[i].se, tv[i].z);
            @(negedge CLK);
            bus.in_valid = 1'b0;
            chk($sformatf("vec%0d_lat1", i), bus.out_valid, 1'b0);
            @(negedge CLK);
            chk($sformatf("vec%0d", i), outs(),
                64'({1'b1, tv[i].z, tv[i].ovf, tv[i].unf, tv[i].e, tv[i].m}));
        end

        sent = 0;
        got  = 0;
        for (int c = 0; c < 40 && got < 4; c++) begin
            @(negedge CLK);
            bus.out_ready = (c >= 4);
            drive(sent < 4, 48'h400000000000, 10'(100 + sent), 1'b0);
            #1;
            if (c == 2) chk("bp_accepts", sent, 2);
            if (c == 2 || c == 3) begin
                chk("bp_in_ready", bus.in_ready, 1'b0);
                chk("bp_hold", {bus.out_valid, bus.final_E_out, bus.final_M_out},
                    {1'b1, 8'd100, 24'h800000});
            end
            acc = bus.in_valid & bus.in_ready;
            drn = bus.out_valid & bus.out_ready;
            de  = bus.final_E_out;
            @(posedge CLK);
            if (acc) sent++;
            if (drn) begin
                chk("bp_drain_order", de, 8'(100 + got));
                got++;
            end
        end
        chk("bp_drain_count", got, 4);
        bus.in_valid = 1'b0;
        @(negedge CLK);
        chk("bp_no_dup", bus.out_valid, 1'b0);

        bus.out_ready = 1'b0;
        @(negedge CLK);
        drive(1'b1, 48'h400000000000, 10'd50, 1'b0);
        @(negedge CLK);
        drive(1'b1, 48'h400000000000, 10'd51, 1'b0);
        @(negedge CLK);
        bus.in_valid = 1'b0;
        chk("full_in_ready", bus.in_ready, 1'b0);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("rst_mid_outs", outs(), 64'h0);
        chk("rst_mid_in_ready", bus.in_ready, 1'b1);
        bus.out_ready = 1'b1;
        drive(1'b1, 48'h400000000000, 10'd60, 1'b0);
        @(negedge CLK);
        bus.in_valid = 1'b0;
        chk("rst_new_lat1", bus.out_valid, 1'b0);
        @(negedge CLK);
        chk("rst_new_out", outs(), 64'({1'b1, 1'b0, 1'b0, 1'b0, 8'd60, 24'h800000}));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
